// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter with a registered serial line.
module uart_tx_fifo #(
  parameter int CLK_HZ  = 12000000,
  parameter int BAUD    = 115200,
  parameter int DIVISOR = CLK_HZ / BAUD,
  parameter int DEPTH   = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          uart_tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [15:0]   RELOAD = 16'(DIVISOR - 1);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    st_q, st_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          rdy_q;
  logic          push, pop, tick;
  assign tick       = baud_q == 16'd0;
  assign tx_ready   = rdy_q && cnt_q < FULL;
  assign push       = tx_valid && tx_ready;
  assign pop        = cnt_q != '0 && (st_q == IDLE || (st_q == STOP && tick));
  assign uart_tx    = tx_q;
  assign busy       = st_q != IDLE || cnt_q != '0;
  assign fifo_count = cnt_q;
  // A pop always lands in START, whether from IDLE or at the end of a stop bit.
  always_comb begin
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    st_d   = pop ? START
           : (!tick || st_q == IDLE) ? st_q
           : st_q == START ? DATA
           : st_q == DATA ? (idx_q == 3'd7 ? STOP : DATA)
           : IDLE;
    baud_d = (tick || st_q == IDLE) ? RELOAD : baud_q - 16'd1;
    idx_d  = st_q == DATA ? idx_q + 3'(tick) : 3'd0;
    sh_d   = pop ? mem[rd_q] : (st_q == DATA && tick) ? sh_q >> 1 : sh_q;
    tx_d   = st_q == START ? 1'b0 : st_q == DATA ? sh_q[0] : 1'b1;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= tx_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      st_q   <= IDLE;
      baud_q <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      rdy_q  <= 1'b0;
    end else begin
      wr_q   <= wr_q + AW'(push);
      rd_q   <= rd_q + AW'(pop);
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      baud_q <= baud_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      tx_q   <= tx_d;
      rdy_q  <= 1'b1;
    end
endmodule
